// File: rtl/pwm_update_arb_pkg.sv
// Shared types and constants for the PWM update arbiter.
package pwm_update_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_e;

  localparam int NUM_CH_DEF  = 12;
  localparam int RATIO_W_DEF = 8;
  localparam int TIMEOUT_DEF = 255;
  localparam int CH_W        = 4;

  // Swerve-rotation group, served first when priority mode is built in.
  localparam int ROT_FIRST = 0;
  localparam int ROT_LAST  = 3;

  localparam int TMR_W = $clog2(TIMEOUT_DEF + 1);

  function automatic int tmr_width(input int timeout);
    return (timeout > TIMEOUT_DEF) ? $clog2(timeout + 1) : TMR_W;
  endfunction

endpackage

// File: rtl/pwm_rr_pick.sv
// Rotating-priority encoder: first set req bit strictly above 'last', wrapping.
module pwm_rr_pick
  import pwm_update_arb_pkg::*;
#(
  parameter int N = NUM_CH_DEF
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] last,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  // Lowest wrapped candidate first, then any candidate above 'last' overrides it.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && j <= int'(last)) begin
        found = 1'b1;
        idx   = CH_W'(j);
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && j > int'(last)) begin
        found = 1'b1;
        idx   = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/pwm_update_arb.sv
// Round-robin grant sequencer from PWM update requests onto the ratio-load bus.
// Define PWM_UPDATE_ARB_PRIO_EN to give channels ROT_FIRST..ROT_LAST strict priority.
module pwm_update_arb
  import pwm_update_arb_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int RATIO_W = RATIO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      fpga_clock,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         pwm_update,
  input  logic [NUM_CH*RATIO_W-1:0] ratio_in,
  output logic                      bus_valid,
  output logic [CH_W-1:0]           bus_ch,
  output logic [RATIO_W-1:0]        bus_ratio,
  input  logic                      bus_ack,
  output logic [NUM_CH-1:0]         pwm_done,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      err_clear
);

  localparam int            TW       = tmr_width(TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [RATIO_W-1:0]  ratio_q, ratio_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic                err_q, err_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic                pick_found;
  logic [CH_W-1:0]     pick_idx;
  logic [RATIO_W-1:0]  ratio_arr [NUM_CH];

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) ratio_arr[n] = ratio_in[n*RATIO_W +: RATIO_W];
  end

`ifdef PWM_UPDATE_ARB_PRIO_EN
  localparam int ROT_N = ROT_LAST - ROT_FIRST + 1;
  localparam int DRV_N = NUM_CH - ROT_N;

  logic [CH_W-1:0] last_rot_q, last_rot_d, last_drv_q, last_drv_d;
  logic [CH_W-1:0] rot_idx, drv_idx;
  logic            rot_found, drv_found;

  pwm_rr_pick #(.N(ROT_N)) u_pick_rot (
    .req(pwm_update[ROT_LAST:ROT_FIRST]), .last(last_rot_q), .found(rot_found), .idx(rot_idx)
  );
  pwm_rr_pick #(.N(DRV_N)) u_pick_drv (
    .req(pwm_update[NUM_CH-1:ROT_LAST+1]), .last(last_drv_q), .found(drv_found), .idx(drv_idx)
  );

  assign pick_found = rot_found | drv_found;
  assign pick_idx   = rot_found ? rot_idx + CH_W'(ROT_FIRST) : drv_idx + CH_W'(ROT_N);

  // Group pointers are kept relative to their own group.
  always_comb begin
    last_rot_d = last_rot_q;
    last_drv_d = last_drv_q;
    if (state_q == IDLE && pick_found) begin
      if (rot_found) last_rot_d = rot_idx;
      else           last_drv_d = drv_idx;
    end
  end

  always_ff @(posedge fpga_clock or negedge reset_n) begin
    if (!reset_n) begin
      last_rot_q <= CH_W'(ROT_N - 1);
      last_drv_q <= CH_W'(DRV_N - 1);
    end else begin
      last_rot_q <= last_rot_d;
      last_drv_q <= last_drv_d;
    end
  end
`else
  logic [CH_W-1:0] last_q, last_d;

  pwm_rr_pick #(.N(NUM_CH)) u_pick (
    .req(pwm_update), .last(last_q), .found(pick_found), .idx(pick_idx)
  );

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && pick_found) last_d = pick_idx;
  end

  always_ff @(posedge fpga_clock or negedge reset_n) begin
    if (!reset_n) last_q <= CH_W'(NUM_CH - 1);
    else          last_q <= last_d;
  end
`endif

  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    ratio_d = ratio_q;
    done_d  = '0;
    timer_d = timer_q;
    err_d   = err_q & ~err_clear;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          ch_d    = pick_idx;
          ratio_d = ratio_arr[pick_idx];
          valid_d = 1'b1;
          timer_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // An ack on the expiry cycle wins, so the error is only raised without one.
        if (bus_ack || timer_q == TMR_LAST) begin
          valid_d      = 1'b0;
          done_d[ch_q] = 1'b1;
          state_d      = HOLD;
          if (!bus_ack) err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fpga_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ch_q    <= '0;
      ratio_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      ratio_q <= ratio_d;
      done_q  <= done_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign bus_valid   = valid_q;
  assign bus_ch      = ch_q;
  assign bus_ratio   = ratio_q;
  assign pwm_done    = done_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule
